// File: rtl/vector_checker.sv
// Stimulus/response checker: streams test vectors into a DUT and compares up to
// NUM_CH observed channels against expected values at per-channel latencies.
module vector_checker #(
    parameter int NUM_CH  = 2,
    parameter int DATA_W  = 32,
    parameter int CTRL_W  = 3,
    parameter int MAX_LAT = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     abort,
    input  logic [15:0]              num_vectors,
    input  logic [NUM_CH*4-1:0]      lat,
    input  logic                     vec_valid,
    output logic                     vec_ready,
    input  logic [CTRL_W-1:0]        vec_ctrl,
    input  logic [NUM_CH*DATA_W-1:0] vec_exp,
    input  logic [NUM_CH-1:0]        vec_chk,
    output logic [CTRL_W-1:0]        ctrl_out,
    input  logic [NUM_CH*DATA_W-1:0] obs,
    output logic [NUM_CH-1:0]        err_pulse,
    output logic [15:0]              err_count,
    output logic [15:0]              first_err_idx,
    output logic [2:0]               first_err_ch,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [1:0]               dbgState
);

    localparam int TAP_W = $clog2(MAX_LAT + 1);
    localparam int CNT_W = $clog2(NUM_CH + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]               state;
    logic [15:0]              numVec;
    logic [15:0]              issued;
    logic [TAP_W-1:0]         latQ     [NUM_CH];
    logic [TAP_W-1:0]         latClamp [NUM_CH];
    logic [TAP_W-1:0]         drainCnt;

    logic [MAX_LAT:0]         srValid;
    logic [NUM_CH*DATA_W-1:0] srExp [MAX_LAT+1];
    logic [NUM_CH-1:0]        srChk [MAX_LAT+1];
    logic [15:0]              srIdx [MAX_LAT+1];

    logic                     accept;
    logic                     lastAccept;
    logic                     checkEn;
    logic [NUM_CH-1:0]        mism;
    logic [CNT_W-1:0]         nErr;
    logic [2:0]               hitCh;
    logic [15:0]              hitIdx;
    logic [16:0]              errSum;

    // Handshake: a vector transfers on any rising edge where vec_valid && vec_ready;
    // vec_ready depends only on registered state, never on vec_valid.
    assign vec_ready  = (state == ST_RUN) && (issued < numVec);
    assign accept     = vec_valid && vec_ready;
    assign lastAccept = accept && ((issued + 16'd1) == numVec);
    assign checkEn    = ((state == ST_RUN) || (state == ST_DRAIN)) && !abort;

    assign busy     = (state == ST_RUN) || (state == ST_DRAIN);
    assign done     = (state == ST_DONE);
    assign pass     = done && (err_count == 16'd0);
    assign dbgState = state;

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (lat[4*c +: 4] > 4'(MAX_LAT)) latClamp[c] = TAP_W'(MAX_LAT);
            else                             latClamp[c] = lat[4*c +: TAP_W];
        end
    end

    // Each channel taps the delay line at its own depth; the lowest mismatching
    // channel supplies the first-error location.
    always_comb begin
        mism   = '0;
        hitCh  = '0;
        hitIdx = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (srValid[latQ[c]] && srChk[latQ[c]][c] &&
                (srExp[latQ[c]][c*DATA_W +: DATA_W] != obs[c*DATA_W +: DATA_W]))
                mism[c] = 1'b1;
        end
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (mism[c]) begin
                hitCh  = 3'(c);
                hitIdx = srIdx[latQ[c]];
            end
        end
        nErr   = CNT_W'($countones(mism));
        errSum = {1'b0, err_count} + 17'(nErr);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            numVec        <= '0;
            issued        <= '0;
            drainCnt      <= '0;
            srValid       <= '0;
            ctrl_out      <= '0;
            err_pulse     <= '0;
            err_count     <= '0;
            first_err_idx <= '0;
            first_err_ch  <= '0;
            for (int c = 0; c < NUM_CH; c++) latQ[c] <= '0;
        end else begin
            err_pulse <= '0;
            if (checkEn) begin
                err_pulse <= mism;
                if (|mism) begin
                    err_count <= errSum[16] ? 16'hFFFF : errSum[15:0];
                    if (err_count == 16'd0) begin
                        first_err_idx <= hitIdx;
                        first_err_ch  <= hitCh;
                    end
                end
            end

            if (abort) begin
                state    <= ST_IDLE;
                srValid  <= '0;
                ctrl_out <= '0;
            end else begin
                case (state)
                    ST_IDLE, ST_DONE: begin
                        if (start) begin
                            state         <= ST_RUN;
                            numVec        <= num_vectors;
                            issued        <= '0;
                            drainCnt      <= '0;
                            srValid       <= '0;
                            err_count     <= '0;
                            first_err_idx <= '0;
                            first_err_ch  <= '0;
                            latQ          <= latClamp;
                        end
                    end
                    ST_RUN: begin
                        srValid  <= {srValid[MAX_LAT-1:0], accept};
                        ctrl_out <= accept ? vec_ctrl : '0;
                        if (accept) issued <= issued + 16'd1;
                        if (lastAccept || (issued == numVec)) begin
                            state    <= ST_DRAIN;
                            drainCnt <= '0;
                        end
                    end
                    ST_DRAIN: begin
                        srValid  <= {srValid[MAX_LAT-1:0], 1'b0};
                        ctrl_out <= '0;
                        if (drainCnt == TAP_W'(MAX_LAT)) state <= ST_DONE;
                        else                             drainCnt <= drainCnt + 1'b1;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // Payload travels with the valid bits; its content is ignored where valid is 0.
    always_ff @(posedge clk) begin
        if (busy) begin
            srExp[0] <= vec_exp;
            srChk[0] <= vec_chk;
            srIdx[0] <= issued;
            for (int i = 1; i <= MAX_LAT; i++) begin
                srExp[i] <= srExp[i-1];
                srChk[i] <= srChk[i-1];
                srIdx[i] <= srIdx[i-1];
            end
        end
    end

endmodule

// File: tb/tb_vector_checker.sv
// Randomized bench for vector_checker: a planned DUT response, a per-channel
// expected-pulse scoreboard and end-of-run result checks.
module tb_vector_checker;

    localparam int MAX_LAT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [15:0] num_vectors;
    logic [7:0]  lat;
    logic        vec_valid;
    logic        vec_ready;
    logic [2:0]  vec_ctrl;
    logic [63:0] vec_exp;
    logic [1:0]  vec_chk;
    logic [2:0]  ctrl_out;
    logic [63:0] obs;
    logic [1:0]  err_pulse;
    logic [15:0] err_count;
    logic [15:0] first_err_idx;
    logic [2:0]  first_err_ch;
    logic        busy;
    logic        done;
    logic        pass;
    logic [1:0]  dbgState;

    vector_checker #(.NUM_CH(2), .DATA_W(32), .CTRL_W(3), .MAX_LAT(MAX_LAT)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .num_vectors(num_vectors), .lat(lat), .vec_valid(vec_valid),
        .vec_ready(vec_ready), .vec_ctrl(vec_ctrl), .vec_exp(vec_exp),
        .vec_chk(vec_chk), .ctrl_out(ctrl_out), .obs(obs),
        .err_pulse(err_pulse), .err_count(err_count),
        .first_err_idx(first_err_idx), .first_err_ch(first_err_ch),
        .busy(busy), .done(done), .pass(pass), .dbgState(dbgState)
    );

    // Clock and edge counter
    always #5 clk = ~clk;
    int edgeNo = 0;
    always @(posedge clk) edgeNo <= edgeNo + 1;

    int tests  = 0;
    int failed = 0;

    // Scoreboard: expected err_pulse edges per channel, and planned obs per edge
    logic [31:0] expQ0[$];
    logic [31:0] expQ1[$];
    logic [31:0] plan0[int];
    logic [31:0] plan1[int];

    // Reference model state for the current run
    int numM, issuedM, totalErr, firstEdge, firstCh, firstIdx, lastAcc;
    int effLat[2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, edgeNo);
        end
    endtask

    task automatic step();
        int nxt;
        nxt = edgeNo + 1;
        obs[31:0]  = plan0.exists(nxt) ? plan0[nxt] : $urandom();
        obs[63:32] = plan1.exists(nxt) ? plan1[nxt] : $urandom();
        if (plan0.exists(nxt)) plan0.delete(nxt);
        if (plan1.exists(nxt)) plan1.delete(nxt);
        @(posedge clk);
        #2;
    endtask

    task automatic clearPlans();
        expQ0.delete();
        expQ1.delete();
        plan0.delete();
        plan1.delete();
    endtask

    task automatic beginRun(input int n, input int l0, input int l1);
        vec_valid   = 1'b0;
        num_vectors = 16'(n);
        lat         = {4'(l1), 4'(l0)};
        start       = 1'b1;
        step();
        start     = 1'b0;
        numM      = n;
        issuedM   = 0;
        totalErr  = 0;
        firstEdge = 32'h7fffffff;
        firstCh   = 0;
        firstIdx  = 0;
        lastAcc   = edgeNo + 1;
        effLat[0] = (l0 > MAX_LAT) ? MAX_LAT : l0;
        effLat[1] = (l1 > MAX_LAT) ? MAX_LAT : l1;
        check("busy_after_start", 64'(busy), 64'(1));
    endtask

    // Offer one vector; if accepted, plan the DUT's response and the expected pulses.
    task automatic driveCycle(input bit valid, input int pErr, input int pChk,
                              input int forceIdx, input int forceCh);
        logic [31:0] ex[2];
        logic [31:0] o;
        logic [1:0]  chk;
        logic [2:0]  ctl;
        bit          acc;
        int          e, f;
        ctl = 3'($urandom_range(7));
        for (int c = 0; c < 2; c++) begin
            ex[c]  = $urandom();
            chk[c] = ($urandom_range(99) < pChk);
        end
        if (issuedM == forceIdx) begin
            ex[forceCh]  = 32'h0000_0010;
            chk[forceCh] = 1'b1;
        end
        vec_valid = valid;
        vec_ctrl  = ctl;
        vec_exp   = {ex[1], ex[0]};
        vec_chk   = chk;
        check("vec_ready", 64'(vec_ready), 64'(issuedM < numM));
        acc = valid && (issuedM < numM);
        e   = edgeNo + 1;
        if (acc) begin
            for (int c = 0; c < 2; c++) begin
                f = e + 1 + effLat[c];
                if (!chk[c])                   o = $urandom();
                else if (issuedM == forceIdx)  o = (c == forceCh) ? 32'hDEAD_BEEF : ex[c];
                else if ($urandom_range(99) < pErr) o = ex[c] ^ ($urandom() | 32'd1);
                else                           o = ex[c];
                if (c == 0) plan0[f] = o;
                else        plan1[f] = o;
                if (chk[c] && (o != ex[c])) begin
                    if (c == 0) expQ0.push_back(32'(f));
                    else        expQ1.push_back(32'(f));
                    totalErr++;
                    if (f < firstEdge || (f == firstEdge && c < firstCh)) begin
                        firstEdge = f;
                        firstCh   = c;
                        firstIdx  = issuedM;
                    end
                end
            end
            issuedM++;
            lastAcc = e;
        end
        step();
        check("ctrl_out", 64'(ctrl_out), acc ? 64'(ctl) : 64'(0));
    endtask

    task automatic finishRun();
        int guard;
        int expCnt;
        vec_valid = 1'b0;
        guard = 0;
        while (guard < 40) begin
            step();
            guard++;
            if (done) break;
            check("drain_ctrl_out", 64'(ctrl_out), 64'(0));
            check("drain_vec_ready", 64'(vec_ready), 64'(0));
        end
        check("done_reached", 64'(done), 64'(1));
        check("done_edge", 64'(edgeNo), 64'(lastAcc + MAX_LAT + 1));
        expCnt = (totalErr > 65535) ? 65535 : totalErr;
        check("busy_at_done", 64'(busy), 64'(0));
        check("state_at_done", 64'(dbgState), 64'(3));
        check("err_count", 64'(err_count), 64'(expCnt));
        check("pass", 64'(pass), 64'(totalErr == 0));
        check("first_err_idx", 64'(first_err_idx), totalErr > 0 ? 64'(firstIdx) : 64'(0));
        check("first_err_ch", 64'(first_err_ch), totalErr > 0 ? 64'(firstCh) : 64'(0));
        step();
        check("pending_pulses", 64'(expQ0.size() + expQ1.size()), 64'(0));
        clearPlans();
    endtask

    task automatic runTest(input int n, input int l0, input int l1, input int pValid,
                           input int pErr, input int pChk, input int forceIdx, input int forceCh);
        int guard;
        beginRun(n, l0, l1);
        guard = 0;
        while (issuedM < n && guard < 4 * n + 100) begin
            driveCycle($urandom_range(99) < pValid, pErr, pChk, forceIdx, forceCh);
            guard++;
        end
        check("all_vectors_accepted", 64'(issuedM), 64'(n));
        finishRun();
    endtask

    // Monitor: every err_pulse must match the front of its channel's expected queue
    always @(negedge clk) begin
        if (!reset) begin
            if (err_pulse[0]) begin
                tests++;
                if (expQ0.size() != 0 && expQ0[0] == 32'(edgeNo)) void'(expQ0.pop_front());
                else begin
                    failed++;
                    $display("FAIL err_pulse0_unexpected: pulse 1 at edge %0d, expected 0", edgeNo);
                end
            end else if (expQ0.size() != 0 && expQ0[0] <= 32'(edgeNo)) begin
                tests++;
                failed++;
                $display("FAIL err_pulse0_missing: pulse 0 at edge %0d, expected 1", expQ0[0]);
                void'(expQ0.pop_front());
            end
            if (err_pulse[1]) begin
                tests++;
                if (expQ1.size() != 0 && expQ1[0] == 32'(edgeNo)) void'(expQ1.pop_front());
                else begin
                    failed++;
                    $display("FAIL err_pulse1_unexpected: pulse 1 at edge %0d, expected 0", edgeNo);
                end
            end else if (expQ1.size() != 0 && expQ1[0] <= 32'(edgeNo)) begin
                tests++;
                failed++;
                $display("FAIL err_pulse1_missing: pulse 0 at edge %0d, expected 1", expQ1[0]);
                void'(expQ1.pop_front());
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; num_vectors = '0; lat = '0;
        vec_valid = 1'b0; vec_ctrl = '0; vec_exp = '0; vec_chk = '0; obs = '0;
        repeat (3) @(posedge clk);
        #2;
        check("reset_outputs", 64'({vec_ready, ctrl_out, err_pulse, err_count, first_err_idx,
                                    first_err_ch, busy, done, pass}), 64'(0));
        check("reset_state", 64'(dbgState), 64'(0));
        reset = 1'b0;
        step();

        runTest(4, 0, 3, 100, 0, 100, -1, 0);        // basic back-to-back
        runTest(4, 0, 3, 100, 0, 100, 2, 1);         // forced DEADBEEF on vector 2 ch 1
        runTest(20, 1, 2, 60, 0, 50, -1, 0);         // bubbles and don't-care
        runTest(3, 2, 2, 100, 100, 100, -1, 0);      // simultaneous mismatches
        for (int i = 0; i < 6; i++)
            runTest($urandom_range(1, 40), $urandom_range(0, 7), $urandom_range(0, 7),
                    $urandom_range(40, 100), $urandom_range(0, 30), $urandom_range(30, 100), -1, 0);
        runTest(0, 1, 1, 100, 0, 100, -1, 0);        // empty run
        runTest(12, 9, 4, 80, 30, 100, -1, 0);       // latency clamp

        // Abort mid-run with mismatches still in flight
        beginRun(10, 4, 4);
        for (int i = 0; i < 3; i++) driveCycle(1'b1, 100, 100, -1, 0);
        vec_valid = 1'b0;
        abort = 1'b1;
        step();
        abort = 1'b0;
        clearPlans();
        check("abort_state", 64'(dbgState), 64'(0));
        check("abort_busy_done", 64'({busy, done}), 64'(0));
        check("abort_ctrl_out", 64'(ctrl_out), 64'(0));
        check("abort_vec_ready", 64'(vec_ready), 64'(0));
        for (int i = 0; i < 8; i++) begin
            step();
            check("abort_err_pulse", 64'(err_pulse), 64'(0));
            check("abort_err_count", 64'(err_count), 64'(0));
        end

        runTest(32770, 1, 1, 100, 100, 100, -1, 0);  // err_count saturation

        // Asynchronous reset during DRAIN
        beginRun(4, 0, 0);
        for (int i = 0; i < 4; i++) driveCycle(1'b1, 100, 100, -1, 0);
        vec_valid = 1'b0;
        step();
        step();
        check("pre_reset_busy", 64'(busy), 64'(1));
        check("pre_reset_err_count", 64'(err_count), 64'(totalErr));
        #1 reset = 1'b1;
        #1;
        check("async_reset_outputs", 64'({vec_ready, ctrl_out, err_pulse, err_count, first_err_idx,
                                          first_err_ch, busy, done, pass}), 64'(0));
        check("async_reset_state", 64'(dbgState), 64'(0));
        clearPlans();
        step();
        step();
        reset = 1'b0;
        step();
        check("post_reset_idle", 64'({busy, done, dbgState}), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/vector_checker.md
# vector_checker

Synthesizable, parametrised stimulus/response checker for pipelined-datapath bring-up. It accepts test vectors over a valid/ready stream, drives each vector's control field into the DUT, and compares up to NUM_CH observed DUT signals against expected values, each at its own pipeline latency. It sits between a vector source (ROM or host FIFO) and the DUT in bench and FPGA bring-up builds. It counts and localises mismatches and reports pass/fail when the stream drains.

## Interface
- NUM_CH, 2: number of checked channels (1..8).
- DATA_W, 32: width of each observed/expected channel.
- CTRL_W, 3: width of the per-vector control field driven to the DUT.
- MAX_LAT, 4: largest supported per-channel latency (1..15).
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin a run; sampled in IDLE or DONE only.
- abort  in  1  synchronous abort; returns to IDLE from any state.
- num_vectors  in  16  vectors in this run; latched at start.
- lat  in  NUM_CH*4  per-channel latency, channel c in bits [4c+3:4c]; latched at start.
- vec_valid  in  1  vector present.
- vec_ready  out  1  checker accepts vector this cycle.
- vec_ctrl  in  CTRL_W  control field to drive to the DUT.
- vec_exp  in  NUM_CH*DATA_W  expected values, channel c in [DATA_W*(c+1)-1:DATA_W*c].
- vec_chk  in  NUM_CH  per-channel check enable (0 = don't care).
- ctrl_out  out  CTRL_W  registered control field to the DUT.
- obs  in  NUM_CH*DATA_W  observed DUT values, same packing as vec_exp.
- err_pulse  out  NUM_CH  one-cycle mismatch flag per channel.
- err_count  out  16  total mismatches, saturating.
- first_err_idx  out  16  vector index of the first mismatch.
- first_err_ch  out  3  channel of the first mismatch.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  high in DONE.
- pass  out  1  done && err_count==0.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE, start=1: latch num_vectors and lat, clear counters and first-error registers, go to RUN. A lat value greater than MAX_LAT is clamped to MAX_LAT.
- RUN: vec_ready=1 while issued<num_vectors.
  - Accept: shift {valid=1, exp, chk, idx=issued} into delay line sr[0..MAX_LAT], set ctrl_out<=vec_ctrl, and increment issued.
  - No accept: shift a bubble (valid=0) and set ctrl_out<=0.
  - When issued==num_vectors (including num_vectors=0), go to DRAIN.
- DRAIN: vec_ready=0, bubbles shift, ctrl_out=0. After MAX_LAT+1 cycles, go to DONE.
- DONE: done=1, pass valid. Outputs hold. start=1 begins a new run as from IDLE.
- Check, every edge in RUN and DRAIN, for each channel c: if sr[lat[c]].valid && chk[c] && exp[c]!=obs[c], then err_pulse[c]=1 and err_count increments.
- Several channels mismatching in one cycle add the number of mismatching channels. err_count saturates at 0xFFFF.
- First-error capture happens only while err_count==0. The lowest mismatching channel index wins, and idx is taken from sr[lat[c]] for that channel.
- start while busy is ignored. abort clears the delay line valid bits, sets ctrl_out=0, keeps counters, and goes to IDLE.

## Timing
- Reset values: state IDLE; vec_ready, ctrl_out, err_pulse, err_count, first_err_idx, first_err_ch, busy, done, pass all 0; all sr valid bits 0.
- Vector accepted at edge k: ctrl_out shows it during cycle k..k+1. Channel with lat=L compares obs sampled at edge k+1+L.
- err_pulse is registered: high in the cycle after the comparing edge. err_count and first_err_* update at that same edge.
- The first vector can be accepted in the first cycle after the start edge.
- Sustained throughput is 1 vector/cycle. Bubbles from vec_valid=0 preserve per-vector alignment.
- done rises MAX_LAT+1 cycles after the cycle issued reaches num_vectors.
- Asynchronous reset mid-run forces reset values immediately; no partial results are retained.

## Test plan
- Basic: NUM_CH=2, lat={0,3}, 4 vectors streaming back-to-back, obs matching at edges k+1 and k+4 -> err_count=0, pass=1, done 5 cycles after the last accept.
- Mismatch: vector 2 channel 1 obs=0xDEADBEEF vs expected 0x00000010 -> single err_pulse[1], err_count=1, first_err_idx=2, first_err_ch=1, pass=0.
- Bubbles plus don't-care: vec_valid low for 2 cycles mid-stream, plus one vector with vec_chk=0 and garbage obs -> ctrl_out=0 during the bubbles, no errors.
- Simultaneous error: channels 0 and 1 mismatch at the same edge -> err_count+=2, first_err_ch=0. Drive 0x10000 mismatches -> err_count stays at 0xFFFF.
- Corner cases: num_vectors=0 -> DONE after MAX_LAT+1 cycles with pass=1. lat=9 with MAX_LAT=4 -> checked at latency 4.
- Abort and reset: abort in RUN -> IDLE next cycle, ctrl_out=0, no further err_pulse. Async reset asserted mid-DRAIN -> all outputs 0 before the next edge.
